// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
//   state_e     : access sequencer states (idle, access in flight, completion cycle)
//   ALIGN_MASK  : low address bits that must be zero for a word access
//   WORD_BYTES  : bytes per data word
//   is_aligned  : word-alignment test on the two low address bits
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  localparam logic [1:0]  ALIGN_MASK = 2'b11;
  localparam int unsigned WORD_BYTES = 4;

  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return (addr_lo & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// One-entry posted store buffer. A fill captures address/data while the entry is
// empty; the entry stays busy until the memory acknowledges the drain.
//   clk, rst     : clock, asynchronous active-high reset
//   fill_i       : capture fill_addr_i/fill_data_i (ignored while busy)
//   drain_ack_i  : memory accepted the buffered store; entry frees
//   busy_o       : entry valid; doubles as the drain request
//   addr_o/data_o: buffered store address/data
module dmem_store_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              drain_ack_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill_i && !valid_q) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      data_q  <= fill_data_i;
    end else if (drain_ack_i) begin
      valid_q <= 1'b0;
    end
  end

  assign busy_o = valid_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: runs one req/ack transaction on a variable-latency data memory
// per load/store from EX/MEM and stalls the pipeline until it completes.
//   clk, rst            : clock, asynchronous active-high reset
//   mem_read_i/write_i  : EX/MEM MemRead/MemWrite (both set = write)
//   addr_i, wdata_i     : byte address and store data
//   stall_o             : freeze front of pipeline, bubble into MEM/WB
//   rdata_o/valid_o     : load result to MEM/WB
//   misalign_o          : one-cycle pulse, misaligned access dropped
//   dmem_*              : memory request channel (req held until ack)
// Optional feature: define DMEM_STORE_BUF_EN for a one-entry posted store buffer.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  state_e state_q, state_d;

  logic              op, aligned;
  logic              stall, start;
  logic              req_q, we_q, is_rd_q;
  logic              rvalid_q, misalign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  assign op      = mem_read_i | mem_write_i;
  assign aligned = is_aligned(addr_i[1:0]);

`ifdef DMEM_STORE_BUF_EN
  logic              buf_busy, buf_fill;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  // The FSM never starts an access while the buffer is busy, so any ack seen
  // while busy belongs to the drain.
  dmem_store_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_store_buf (
    .clk        (clk),
    .rst        (rst),
    .fill_i     (buf_fill),
    .fill_addr_i(addr_i),
    .fill_data_i(wdata_i),
    .drain_ack_i(dmem_ack_i & buf_busy),
    .busy_o     (buf_busy),
    .addr_o     (buf_addr),
    .data_o     (buf_data)
  );
`endif

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    start   = 1'b0;
`ifdef DMEM_STORE_BUF_EN
    buf_fill = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (op && aligned) begin
`ifdef DMEM_STORE_BUF_EN
          if (buf_busy) begin
            // Wait for the drain; the op is retried from idle afterwards.
            stall = 1'b1;
          end else if (mem_write_i && !mem_read_i) begin
            buf_fill = 1'b1;
          end else begin
            stall   = 1'b1;
            start   = 1'b1;
            state_d = StAccess;
          end
`else
          stall   = 1'b1;
          start   = 1'b1;
          state_d = StAccess;
`endif
        end
      end
      StAccess: begin
        stall = 1'b1;
        if (dmem_ack_i) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= (state_q == StIdle) && op && !aligned;
      rvalid_q   <= (state_q == StAccess) && dmem_ack_i && is_rd_q;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= mem_write_i;
        is_rd_q <= mem_read_i & ~mem_write_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state_q == StAccess && dmem_ack_i) begin
        req_q <= 1'b0;
        if (is_rd_q) rdata_q <= dmem_rdata_i;
      end
    end
  end

  // Gate with rst so the pipeline is released immediately during reset.
  assign stall_o       = stall & ~rst;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign misalign_o    = misalign_q;

`ifdef DMEM_STORE_BUF_EN
  assign dmem_req_o   = req_q | buf_busy;
  assign dmem_we_o    = buf_busy ? 1'b1 : we_q;
  assign dmem_addr_o  = buf_busy ? buf_addr : addr_q;
  assign dmem_wdata_o = buf_busy ? buf_data : wdata_q;
`else
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk, rst;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, rdata_valid_o, misalign_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  // Memory device (driven by what the DUT presents) and reference model
  // (updated only from the stimulus).
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_load;
  int          ack_lat;
  int          wait_cnt;
  bit          resp_en;

  dmem_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .misalign_o   (misalign_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Advance to the next negedge and play the memory device for that cycle.
  task automatic step();
    @(negedge clk);
    dmem_ack_i = 1'b0;
    if (resp_en && dmem_req_o === 1'b1 && !rst) begin
      if (wait_cnt >= ack_lat) begin
        dmem_ack_i = 1'b1;
        if (dmem_we_o) begin
          dev_mem[dmem_addr_o] = dmem_wdata_o;
          dmem_rdata_i = $urandom;
        end else begin
          dmem_rdata_i = dev_rd(dmem_addr_o);
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic set_idle();
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
  endtask

  // One MEM-stage operation: expected stall length is 2 + latency for an aligned
  // access (idle cycle + access cycles), zero for a misaligned one.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
    logic        exp_rd;
    logic [31:0] exp_data;
    int          stalls;
    bit          ack_seen;
    exp_rd   = rd & ~wr;
    exp_data = ref_rd(a);
    ack_lat  = lat;
    step();
    mem_read_i  = rd;
    mem_write_i = wr;
    addr_i      = a;
    wdata_i     = d;
    #1;
    n_checks++;
    if (rdata_valid_o !== 1'b0 || misalign_o !== 1'b0 || rdata_o !== last_load) begin
      n_errors++;
      $display("FAIL idle_outs got rv=%b mis=%b rdata=%h want rv=0 mis=0 rdata=%h",
               rdata_valid_o, misalign_o, rdata_o, last_load);
    end
    if (a[1:0] != 2'b00) begin
      n_checks++;
      if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        n_errors++;
        $display("FAIL misalign_nostall got stall=%b req=%b want 0 0", stall_o, dmem_req_o);
      end
      step();
      set_idle();
      #1;
      n_checks++;
      if (misalign_o !== 1'b1 || dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
        n_errors++;
        $display("FAIL misalign_pulse got mis=%b req=%b stall=%b want 1 0 0",
                 misalign_o, dmem_req_o, stall_o);
      end
      return;
    end
    stalls   = 0;
    ack_seen = 0;
    while (stall_o === 1'b1 && stalls < 200) begin
      if (dmem_ack_i === 1'b1) begin
        ack_seen = 1;
        n_checks++;
        if (dmem_addr_o !== a || dmem_we_o !== wr || (wr && dmem_wdata_o !== d)) begin
          n_errors++;
          $display("FAIL req_fields got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                   dmem_addr_o, dmem_we_o, dmem_wdata_o, a, wr, d);
        end
      end
      stalls++;
      step();
      #1;
    end
    n_checks++;
    if (stalls != 2 + lat || !ack_seen) begin
      n_errors++;
      $display("FAIL stall_len got %0d ack_seen=%0d want %0d ack_seen=1", stalls, ack_seen,
               2 + lat);
    end
    n_checks++;
    if (rdata_valid_o !== exp_rd || dmem_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL done_cycle got rv=%b req=%b want rv=%b req=0", rdata_valid_o, dmem_req_o,
               exp_rd);
    end
    if (exp_rd) begin
      n_checks++;
      if (rdata_o !== exp_data) begin
        n_errors++;
        $display("FAIL load_data a=%h got %h want %h", a, rdata_o, exp_data);
      end
      last_load = exp_data;
    end
    if (wr) ref_mem[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({stall_o, rdata_valid_o, misalign_o, dmem_req_o, dmem_we_o} !== 5'b0 ||
        rdata_o !== 32'h0 || dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_vals got st=%b rv=%b mis=%b req=%b we=%b rd=%h ad=%h wd=%h want 0",
               stall_o, rdata_valid_o, misalign_o, dmem_req_o, dmem_we_o, rdata_o,
               dmem_addr_o, dmem_wdata_o);
    end
    rst = 1'b0;
    last_load = 32'h0;
  endtask

  task automatic test_load();
    dev_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 2);
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b1, 32'h104, 32'h12345678, 0);
    run_op(1'b1, 1'b0, 32'h104, 32'h0, 1);
  endtask

  task automatic test_misalign();
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 0);
    run_op(1'b0, 1'b1, 32'h107, 32'h1111_2222, 0);
  endtask

  task automatic test_reset_mid_access();
    ack_lat = 3;
    step();
    mem_read_i = 1'b1;
    addr_i     = 32'h200;
    #1;
    step();
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b1 || stall_o !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset_access got req=%b stall=%b want 1 1", dmem_req_o, stall_o);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || dmem_addr_o !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset got req=%b stall=%b addr=%h want 0 0 0", dmem_req_o, stall_o,
               dmem_addr_o);
    end
    set_idle();
    step();
    rst = 1'b0;
    last_load = 32'h0;
    resp_en = 0;
    step();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    step();
    dmem_ack_i = 1'b0;
    #1;
    n_checks++;
    if (rdata_o !== 32'h0 || rdata_valid_o !== 1'b0 || dmem_req_o !== 1'b0 ||
        stall_o !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_ack got rd=%h rv=%b req=%b stall=%b want 0 0 0 0", rdata_o,
               rdata_valid_o, dmem_req_o, stall_o);
    end
    resp_en = 1;
    run_op(1'b1, 1'b0, 32'h200, 32'h0, 1);
  endtask

  task automatic test_read_write();
    run_op(1'b1, 1'b1, 32'h108, 32'hA1B2C3D4, 1);
    run_op(1'b1, 1'b0, 32'h108, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a    = 32'h300 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run_op(kind != 1, kind == 1 || kind == 2, a, $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) begin
        step();
        set_idle();
        #1;
      end
    end
  endtask

`ifdef DMEM_STORE_BUF_EN
  task automatic test_store_buf();
    int stalls;
    ack_lat = 5;
    step();
    mem_write_i = 1'b1;
    addr_i      = 32'h400;
    wdata_i     = 32'hA5A50F0F;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_errors++;
      $display("FAIL posted_store_stall got %b want 0", stall_o);
    end
    step();
    mem_write_i = 1'b0;
    mem_read_i  = 1'b1;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== 32'h400 ||
        dmem_wdata_o !== 32'hA5A50F0F) begin
      n_errors++;
      $display("FAIL drain_req got req=%b we=%b ad=%h wd=%h want 1 1 400 a5a50f0f", dmem_req_o,
               dmem_we_o, dmem_addr_o, dmem_wdata_o);
    end
    stalls = 0;
    while (stall_o === 1'b1 && stalls < 200) begin
      stalls++;
      step();
      #1;
    end
    n_checks++;
    if (stalls != 13) begin
      n_errors++;
      $display("FAIL buf_load_stall got %0d want 13", stalls);
    end
    n_checks++;
    if (rdata_valid_o !== 1'b1 || rdata_o !== 32'hA5A50F0F) begin
      n_errors++;
      $display("FAIL buf_load_data got rv=%b rd=%h want 1 a5a50f0f", rdata_valid_o, rdata_o);
    end
    ref_mem[32'h400] = 32'hA5A50F0F;
    last_load = 32'hA5A50F0F;
    step();
    set_idle();
    #1;
  endtask
`endif

  initial begin
    resp_en      = 1;
    wait_cnt     = 0;
    ack_lat      = 0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = '0;
    last_load    = '0;
    set_idle();
    test_reset();
    test_load();
    test_misalign();
    test_reset_mid_access();
`ifdef DMEM_STORE_BUF_EN
    test_store_buf();
`else
    test_store();
    test_read_write();
    test_random();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
